// File: rtl/nrisc_data_arbiter.sv
`default_nettype none
// ============================================================================
// nrisc_data_arbiter : round-robin CPU/AUX arbiter and access sequencer for a
//                      single-port data memory with fixed read latency.
// Revision 1.0
// ============================================================================
module nrisc_data_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if ((MEM_LAT < 1) || (MEM_LAT > 8)) begin : g_bad_mem_lat
        $error("nrisc_data_arbiter: MEM_LAT must be in 1..8");
    end

    // WAIT covers the MEM_LAT-1 cycles after ISSUE; RESP is the cycle in
    // which mem_rdata is valid, so the registered rvalid lands at ISSUE+MEM_LAT+1.
    localparam logic [3:0] c_LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_owner_aux;
    logic                r_last_aux;
    logic                r_cpu_gnt;
    logic                r_aux_gnt;
    logic                r_cpu_rvalid;
    logic                r_aux_rvalid;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_aux_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_busy;
    logic                w_any_req;
    logic                w_pick_aux;

    assign w_any_req  = cpu_req | aux_req;
    assign w_pick_aux = aux_req & (~cpu_req | ~r_last_aux);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_ISSUE;
            S_ISSUE: begin
                if (r_mem_we)
                    w_next = S_IDLE;
                else if (c_LAT_M1 == 4'd0)
                    w_next = S_RESP;
                else
                    w_next = S_WAIT;
            end
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_owner_aux  <= 1'b0;
            r_last_aux   <= 1'b1;
            r_cpu_gnt    <= 1'b0;
            r_aux_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_aux_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_aux_rdata  <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_cpu_gnt    <= 1'b0;
            r_aux_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_aux_rvalid <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // mem_addr/mem_wdata double as the latched request fields.
                    if (w_any_req) begin
                        r_owner_aux <= w_pick_aux;
                        r_last_aux  <= w_pick_aux;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_pick_aux ? aux_we    : cpu_we;
                        r_mem_addr  <= w_pick_aux ? aux_addr  : cpu_addr;
                        r_mem_wdata <= w_pick_aux ? aux_wdata : cpu_wdata;
                        r_cpu_gnt   <= ~w_pick_aux;
                        r_aux_gnt   <= w_pick_aux;
                    end
                end
                S_ISSUE: begin
                    if (!r_mem_we) r_cnt <= c_LAT_M1;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    r_cnt <= 4'd0;
                    if (r_owner_aux) begin
                        r_aux_rdata  <= mem_rdata;
                        r_aux_rvalid <= 1'b1;
                    end else begin
                        r_cpu_rdata  <= mem_rdata;
                        r_cpu_rvalid <= 1'b1;
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign aux_gnt    = r_aux_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign aux_rvalid = r_aux_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign aux_rdata  = r_aux_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nrisc_data_arbiter.sv
`default_nettype none
// ============================================================================
// tb_nrisc_data_arbiter : directed bench for nrisc_data_arbiter, MEM_LAT=2 and 1.
// Revision 1.0
// ============================================================================
module tb_nrisc_data_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    // DUT A: MEM_LAT = 2
    logic        a_cpu_req, a_cpu_we, a_cpu_gnt, a_cpu_rvalid;
    logic [15:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic        a_aux_req, a_aux_we, a_aux_gnt, a_aux_rvalid;
    logic [15:0] a_aux_addr, a_aux_wdata, a_aux_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // DUT B: MEM_LAT = 1
    logic        b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_rvalid;
    logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic        b_aux_req, b_aux_we, b_aux_gnt, b_aux_rvalid;
    logic [15:0] b_aux_addr, b_aux_wdata, b_aux_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    nrisc_data_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
        .aux_req(a_aux_req), .aux_we(a_aux_we), .aux_addr(a_aux_addr), .aux_wdata(a_aux_wdata),
        .aux_gnt(a_aux_gnt), .aux_rvalid(a_aux_rvalid), .aux_rdata(a_aux_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    nrisc_data_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .aux_req(b_aux_req), .aux_we(b_aux_we), .aux_addr(b_aux_addr), .aux_wdata(b_aux_wdata),
        .aux_gnt(b_aux_gnt), .aux_rvalid(b_aux_rvalid), .aux_rdata(b_aux_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] addr);
        case (addr)
            16'h0010: rom = 16'hBEEF;
            16'h0001: rom = 16'hAAAA;
            16'h0002: rom = 16'h5555;
            default:  rom = addr ^ 16'h5A5A;
        endcase
    endfunction

    // Memory models: read data is valid only exactly MEM_LAT cycles after mem_en.
    logic [1:0]  a_v;
    logic [15:0] a_d0, a_d1;
    logic        b_v;
    logic [15:0] b_d;

    always @(posedge clk) begin
        a_v[0] <= a_mem_en & ~a_mem_we;
        a_d0   <= rom(a_mem_addr);
        a_v[1] <= a_v[0];
        a_d1   <= a_d0;
        b_v    <= b_mem_en & ~b_mem_we;
        b_d    <= rom(b_mem_addr);
    end

    assign a_mem_rdata = (a_v[1] === 1'b1) ? a_d1 : 16'hDEAD;
    assign b_mem_rdata = (b_v === 1'b1) ? b_d : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_aux_req = 0; a_aux_we = 0; a_aux_addr = 0; a_aux_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_aux_req = 0; b_aux_we = 0; b_aux_addr = 0; b_aux_wdata = 0;
        step(); step();

        // Reset state
        chk("rst_ctl", {30'd0, a_busy, a_mem_en}, 32'd0);
        chk("rst_gnt", {28'd0, a_cpu_gnt, a_aux_gnt, a_cpu_rvalid, a_aux_rvalid}, 32'd0);
        chk("rst_addr", {16'd0, a_mem_addr}, 32'd0);
        chk("rst_rdata", {a_cpu_rdata, a_aux_rdata}, 32'd0);
        rst = 1'b0;
        step();

        // 1: CPU read 0x0010 -> 0xBEEF, rvalid at n+3
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
        step();
        chk("t1_gnt", {29'd0, a_cpu_gnt, a_aux_gnt, a_mem_en}, 32'b101);
        chk("t1_mem", {15'd0, a_mem_we, a_mem_addr}, 32'h0000_0010);
        a_cpu_req = 0;
        step();
        chk("t1_n1_rv", {31'd0, a_cpu_rvalid}, 32'd0);
        step();
        chk("t1_n2_rv", {30'd0, a_cpu_rvalid, a_busy}, 32'b01);
        step();
        chk("t1_n3_rv", {30'd0, a_cpu_rvalid, a_aux_rvalid}, 32'b10);
        chk("t1_rdata", {16'd0, a_cpu_rdata}, 32'h0000_BEEF);
        step();
        chk("t1_n4", {31'd0, a_cpu_rvalid}, 32'd0);
        chk("t1_hold", {16'd0, a_cpu_rdata}, 32'h0000_BEEF);

        // 2: AUX write 0x0020 <= 0x1234
        a_aux_req = 1; a_aux_we = 1; a_aux_addr = 16'h0020; a_aux_wdata = 16'h1234;
        step();
        chk("t2_gnt", {28'd0, a_aux_gnt, a_cpu_gnt, a_mem_en, a_mem_we}, 32'b1011);
        chk("t2_mem", {a_mem_addr, a_mem_wdata}, 32'h0020_1234);
        a_aux_req = 0;
        step();
        chk("t2_after", {27'd0, a_busy, a_mem_en, a_mem_we, a_aux_rvalid, a_cpu_rvalid}, 32'd0);
        chk("t2_addr_hold", {16'd0, a_mem_addr}, 32'h0000_0020);

        // 3: both write continuously after reset -> CPU, AUX, CPU, AUX every 2 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h0030; a_cpu_wdata = 16'h1111;
        a_aux_req = 1; a_aux_we = 1; a_aux_addr = 16'h0040; a_aux_wdata = 16'h2222;
        step();
        chk("t3_g0", {28'd0, a_cpu_gnt, a_aux_gnt, a_mem_en, a_mem_we}, 32'b1011);
        chk("t3_g0_addr", {16'd0, a_mem_addr}, 32'h0000_0030);
        step();
        chk("t3_gap0", {29'd0, a_cpu_gnt, a_aux_gnt, a_mem_en}, 32'd0);
        step();
        chk("t3_g1", {29'd0, a_cpu_gnt, a_aux_gnt, a_mem_en}, 32'b011);
        chk("t3_g1_data", {a_mem_addr, a_mem_wdata}, 32'h0040_2222);
        step();
        step();
        chk("t3_g2", {30'd0, a_cpu_gnt, a_aux_gnt}, 32'b10);
        step();
        step();
        chk("t3_g3", {30'd0, a_cpu_gnt, a_aux_gnt}, 32'b01);
        a_cpu_req = 0; a_aux_req = 0;
        step();
        chk("t3_idle", {31'd0, a_busy}, 32'd0);

        // 4: CPU back-to-back reads, AUX raises one read in between
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
        step();
        chk("t4_cpu_g0", {30'd0, a_cpu_gnt, a_aux_gnt}, 32'b10);
        a_cpu_addr = 16'h0001;
        a_aux_req = 1; a_aux_we = 0; a_aux_addr = 16'h0002;
        step(); step(); step();
        chk("t4_cpu_rv0", {29'd0, a_cpu_rvalid, a_aux_rvalid, a_cpu_gnt}, 32'b100);
        chk("t4_cpu_rd0", {16'd0, a_cpu_rdata}, 32'h0000_BEEF);
        step();
        chk("t4_aux_g", {30'd0, a_cpu_gnt, a_aux_gnt}, 32'b01);
        chk("t4_aux_addr", {16'd0, a_mem_addr}, 32'h0000_0002);
        a_aux_req = 0;
        step(); step(); step();
        chk("t4_aux_rv", {30'd0, a_aux_rvalid, a_cpu_rvalid}, 32'b10);
        chk("t4_aux_rd", {a_aux_rdata, a_cpu_rdata}, 32'h5555_BEEF);
        step();
        chk("t4_cpu_g1", {30'd0, a_cpu_gnt, a_aux_gnt}, 32'b10);
        chk("t4_cpu_addr", {16'd0, a_mem_addr}, 32'h0000_0001);
        a_cpu_req = 0;
        step(); step(); step();
        chk("t4_cpu_rv1", {30'd0, a_cpu_rvalid, a_aux_rvalid}, 32'b10);
        chk("t4_cpu_rd1", {a_cpu_rdata, a_aux_rdata}, 32'hAAAA_5555);

        // 5: reset during WAIT of a CPU read
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
        step();
        chk("t5_gnt", {31'd0, a_cpu_gnt}, 32'd1);
        a_cpu_req = 0;
        step();
        chk("t5_wait_busy", {31'd0, a_busy}, 32'd1);
        rst = 1'b1;
        step();
        chk("t5_rst_ctl", {25'd0, a_cpu_gnt, a_aux_gnt, a_cpu_rvalid, a_aux_rvalid,
                           a_mem_en, a_mem_we, a_busy}, 32'd0);
        chk("t5_rst_mem", {a_mem_addr, a_mem_wdata}, 32'd0);
        chk("t5_rst_rd", {a_cpu_rdata, a_aux_rdata}, 32'd0);
        rst = 1'b0;
        step();
        chk("t5_no_rv", {30'd0, a_cpu_rvalid, a_busy}, 32'd0);
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h0050; a_cpu_wdata = 16'h0A0A;
        a_aux_req = 1; a_aux_we = 1; a_aux_addr = 16'h0060; a_aux_wdata = 16'h0B0B;
        step();
        chk("t5_tie", {30'd0, a_cpu_gnt, a_aux_gnt}, 32'b10);
        a_cpu_req = 0; a_aux_req = 0;
        step();

        // 6: MEM_LAT=1, CPU reads 0x0001 then 0x0002
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h0001;
        step();
        chk("t6_g0", {15'd0, b_cpu_gnt, b_mem_addr}, 32'h0001_0001);
        b_cpu_addr = 16'h0002;
        step();
        chk("t6_n1", {30'd0, b_cpu_gnt, b_cpu_rvalid}, 32'd0);
        step();
        chk("t6_rv0", {15'd0, b_cpu_rvalid, b_cpu_rdata}, 32'h0001_AAAA);
        step();
        chk("t6_g1", {15'd0, b_cpu_gnt, b_mem_addr}, 32'h0001_0002);
        b_cpu_req = 0;
        step();
        chk("t6_hold", {15'd0, b_cpu_rvalid, b_cpu_rdata}, 32'h0000_AAAA);
        step();
        chk("t6_rv1", {15'd0, b_cpu_rvalid, b_cpu_rdata}, 32'h0001_5555);
        chk("t6_aux_quiet", {15'd0, b_aux_rvalid, b_aux_rdata}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
